alu_seq: RTL
============

// Module: alu_seq
// PURPOSE
//  Parametrised multi-cycle successor of the mMIPS ALU. It keeps the single-cycle logic, arithmetic, compare and clip ops.
//  Adds a variable-amount shifter, iterative signed/unsigned multiply and an optional unsigned divide.
//  Uses a start/done handshake. Sits in EX stage; the pipeline stalls on busy. r2 feeds the HI register, r feeds LO/writeback.
// PARAMETERS
//  WIDTH     32   datapath width in bits; even, >=8
//  CLIP_MAX  255  upper saturation bound for CLIP (op 0x30), unsigned, < 2**(WIDTH-1)
// PORTS
//  clk    in   1             rising-edge clock
//  rst    in   1             asynchronous, active-high reset
//  start  in   1             launch op; sampled only when busy=0
//  ctrl   in   6             opcode (see BEHAVIOUR)
//  a      in   WIDTH         operand s
//  b      in   WIDTH         operand t
//  shamt  in   $clog2(WIDTH) shift amount for SLL/SRL/SRA
//  busy   out  1             op in flight; start ignored
//  done   out  1             one-cycle pulse; r/r2/z/err valid and held until next done
//  r      out  WIDTH         result / product low / quotient
//  r2     out  WIDTH         product high / remainder; 0 for single-cycle ops
//  z      out  1             1 iff r==0, for every op
//  err    out  1             1 for unsupported opcode (r=r2=0)
// BEHAVIOUR
//  Clock and reset: one clock; reset is asynchronous and active-high.
//  Reset: state=IDLE; busy=0, done=0, r=0, r2=0, z=1, err=0. Asserting rst mid-op aborts it with no done pulse.
//  Opcodes:
//   00 AND, 01 OR, 02 ADD, 03 ADDU, 04 XOR, 06 SUB
//   07 SLT (signed), 08 SLTU
//   09 LUI (b<<WIDTH/2)
//   0A SLL, 0D SRL, 0E SRA: by shamt
//   13 MULTU, 14 MULT (signed)
//   15 DIVU (macro-gated)
//   30 CLIP: signed a>CLIP_MAX -> CLIP_MAX; a<0 -> 0; else a
//  Adds wrap modulo 2**WIDTH; there is no overflow trap.
//  FSM: IDLE -> (start & single-cycle op) -> DONE -> IDLE. Latency 1: done in the cycle after start.
//       IDLE -> (start & MUL/DIV) -> ITER (WIDTH cycles, counter WIDTH-1..0) -> DONE -> IDLE. Latency WIDTH+1.
//       busy=1 in ITER and DONE; a new start is accepted in the cycle after done (IDLE).
//  Operands are latched at start; later changes to a/b/ctrl/shamt do not affect the op in flight.
//  MUL: shift-add, 1 bit/cycle, 2*WIDTH accumulator, {r2,r} = product.
//       MULT uses magnitudes, then negates the 2*WIDTH product if the operand signs differ.
//       Most-negative * most-negative must yield the exact 2*WIDTH result.
//  z and err are registered with r. The previous r/r2 stay visible until the next done.
// CONFIGURATION
//  ALU_SEQ_DIVU_EN defined:
//   op 15 = restoring DIVU, 1 bit/cycle, WIDTH+1 latency; r=a/b, r2=a%b.
//   b==0: r=all-ones, r2=a, err=0.
//  ALU_SEQ_DIVU_EN undefined: op 15 is unsupported -> 1-cycle done with err=1, r=r2=0.
// STRUCTURE
//  Package alu_seq_pkg:
//   opcode localparams (OP_AND..OP_CLIP), FSM state encoding (IDLE/ITER/DONE), and
//   function is_multicycle(op) shared with the decode/stall logic.
//  Sub-module alu_muldiv_seq: iterative shift-add multiplier / restoring divider (accumulator, counter, sign fix-up).
//   Handshake: go/ready.
//  Top: single-cycle combinational ops, result mux and registers, control FSM.
// TESTING (WIDTH=32, CLIP_MAX=255)
//  1 ADD a=7FFFFFFF b=1 start -> done next cycle, r=80000000, r2=0, z=0, err=0
//  2 SRA a=x b=80000010 shamt=4 -> r=F8000001. SLL shamt=31, b=1 -> r=80000000
//  3 MULT a=FFFFFFFE(-2) b=3 -> busy 33 cycles, done; r2=FFFFFFFF, r=FFFFFFFA.
//    MULTU a=b=FFFFFFFF -> r2=FFFFFFFE, r=00000001
//  4 CLIP a=00000190 -> r=FF; a=FFFFFFF0 -> r=0, z=1; a=80 -> r=80.
//    Unused op 3F -> err=1, r=0
//  5 start pulsed at cycles 2 and 10 of a MULTU (new a/b) -> ignored, result unchanged.
//    rst at cycle 10 -> busy=0, no done, r=0
//  6 DIVU (EN) a=64 b=7 -> r=E, r2=2; b=0 -> r=FFFFFFFF, r2=64.
//    (no EN) op 15 -> err=1 after 1 cycle

Source files
------------

// File: rtl/alu_seq_pkg.sv
// alu_seq shared definitions: opcodes, FSM states, multi-cycle decode.
// ALU_SEQ_DIVU_EN enables the iterative unsigned divide (op 0x15).
package alu_seq_pkg;

  localparam logic [5:0] OP_AND   = 6'h00;
  localparam logic [5:0] OP_OR    = 6'h01;
  localparam logic [5:0] OP_ADD   = 6'h02;
  localparam logic [5:0] OP_ADDU  = 6'h03;
  localparam logic [5:0] OP_XOR   = 6'h04;
  localparam logic [5:0] OP_SUB   = 6'h06;
  localparam logic [5:0] OP_SLT   = 6'h07;
  localparam logic [5:0] OP_SLTU  = 6'h08;
  localparam logic [5:0] OP_LUI   = 6'h09;
  localparam logic [5:0] OP_SLL   = 6'h0A;
  localparam logic [5:0] OP_SRL   = 6'h0D;
  localparam logic [5:0] OP_SRA   = 6'h0E;
  localparam logic [5:0] OP_MULTU = 6'h13;
  localparam logic [5:0] OP_MULT  = 6'h14;
  localparam logic [5:0] OP_DIVU  = 6'h15;
  localparam logic [5:0] OP_CLIP  = 6'h30;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic is_multicycle(input logic [5:0] op);
`ifdef ALU_SEQ_DIVU_EN
    return (op == OP_MULTU) || (op == OP_MULT) || (op == OP_DIVU);
`else
    return (op == OP_MULTU) || (op == OP_MULT);
`endif
  endfunction

endpackage

// File: rtl/alu_muldiv_seq.sv
// Iterative engine: 1 bit/cycle shift-add multiply or restoring divide.
// Result of the final step is presented combinationally alongside ready.
module alu_muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic             div,
  input  logic             sgn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [WIDTH-1:0]   opb;
  logic [CW-1:0]      cnt;
  logic               active;
  logic               neg;
  logic               div_q;

  logic [WIDTH-1:0]   hi_n;
  logic [WIDTH-1:0]   lo_n;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     sh;
  logic [WIDTH:0]     diff;
  logic               ge;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] res;

  always_comb begin
    sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
    sh   = {acc_hi, acc_lo[WIDTH-1]};
    diff = sh - {1'b0, opb};
    ge   = (sh >= {1'b0, opb});
    if (div_q) begin
      hi_n = ge ? diff[WIDTH-1:0] : sh[WIDTH-1:0];
      lo_n = {acc_lo[WIDTH-2:0], ge};
    end else begin
      hi_n = sum[WIDTH:1];
      lo_n = {sum[0], acc_lo[WIDTH-1:1]};
    end
    prod = {hi_n, lo_n};
    // signed multiply runs on magnitudes; restore the sign here
    res  = neg ? (~prod + 1'b1) : prod;
  end

  assign lo    = res[WIDTH-1:0];
  assign hi    = res[2*WIDTH-1:WIDTH];
  assign ready = active && (cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_hi <= '0;
      acc_lo <= '0;
      opb    <= '0;
      cnt    <= '0;
      active <= 1'b0;
      neg    <= 1'b0;
      div_q  <= 1'b0;
    end else if (go) begin
      acc_hi <= '0;
      acc_lo <= (sgn && a[WIDTH-1]) ? (~a + 1'b1) : a;
      opb    <= (sgn && b[WIDTH-1]) ? (~b + 1'b1) : b;
      cnt    <= CW'(WIDTH - 1);
      active <= 1'b1;
      neg    <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
      div_q  <= div;
    end else if (active) begin
      acc_hi <= hi_n;
      acc_lo <= lo_n;
      cnt    <= cnt - 1'b1;
      if (cnt == '0)
        active <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle EX-stage ALU with start/done handshake.
// Define ALU_SEQ_DIVU_EN to enable DIVU (op 0x15); otherwise it reports err.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int CLIP_MAX = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [5:0]               ctrl,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  input  logic [$clog2(WIDTH)-1:0] shamt,
  output logic                     busy,
  output logic                     done,
  output logic [WIDTH-1:0]         r,
  output logic [WIDTH-1:0]         r2,
  output logic                     z,
  output logic                     err
);

  localparam logic [WIDTH-1:0] CLIP_V = WIDTH'(CLIP_MAX);

  state_t           state_q;
  state_t           state_d;
  logic             multi;
  logic             go;
  logic             load_sc;
  logic             load_md;
  logic             md_div;
  logic             md_ready;
  logic [WIDTH-1:0] md_lo;
  logic [WIDTH-1:0] md_hi;
  logic [WIDTH-1:0] sc_r;
  logic             sc_err;

  assign multi = is_multicycle(ctrl);

`ifdef ALU_SEQ_DIVU_EN
  assign md_div = (ctrl == OP_DIVU);
`else
  assign md_div = 1'b0;
`endif

  always_comb begin
    sc_r   = '0;
    sc_err = 1'b0;
    unique case (ctrl)
      OP_AND:  sc_r = a & b;
      OP_OR:   sc_r = a | b;
      OP_ADD,
      OP_ADDU: sc_r = a + b;
      OP_XOR:  sc_r = a ^ b;
      OP_SUB:  sc_r = a - b;
      OP_SLT:  sc_r = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: sc_r = {{(WIDTH-1){1'b0}}, a < b};
      OP_LUI:  sc_r = b << (WIDTH / 2);
      OP_SLL:  sc_r = b << shamt;
      OP_SRL:  sc_r = b >> shamt;
      OP_SRA:  sc_r = $signed(b) >>> shamt;
      OP_CLIP: begin
        if (a[WIDTH-1])
          sc_r = '0;
        else if (a > CLIP_V)
          sc_r = CLIP_V;
        else
          sc_r = a;
      end
      default: sc_err = 1'b1;
    endcase
  end

  alu_muldiv_seq #(
    .WIDTH(WIDTH)
  ) u_muldiv (
    .clk  (clk),
    .rst  (rst),
    .go   (go),
    .div  (md_div),
    .sgn  (ctrl == OP_MULT),
    .a    (a),
    .b    (b),
    .ready(md_ready),
    .lo   (md_lo),
    .hi   (md_hi)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = multi ? S_ITER : S_DONE;
      S_ITER: if (md_ready) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q != S_IDLE);
    done    = (state_q == S_DONE);
    go      = (state_q == S_IDLE) && start && multi;
    load_sc = (state_q == S_IDLE) && start && !multi;
    load_md = (state_q == S_ITER) && md_ready;
  end

  // results stay put between done pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r   <= '0;
      r2  <= '0;
      z   <= 1'b1;
      err <= 1'b0;
    end else if (load_sc) begin
      r   <= sc_r;
      r2  <= '0;
      z   <= (sc_r == '0);
      err <= sc_err;
    end else if (load_md) begin
      r   <= md_lo;
      r2  <= md_hi;
      z   <= (md_lo == '0);
      err <= 1'b0;
    end
  end

endmodule
